i3c_daa_seq: RTL and testbench

I3C_DAA_SEQ -- requirements
Module: i3c_daa_seq

---
 rtl/i3c_daa_seq_pkg.sv | 25 ++
 rtl/i3c_daa_seq.sv | 153 +++++++++++++++
 tb/tb_i3c_daa_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_daa_seq_pkg.sv
// Shared state encoding and bit-position counter constants for the I3C ENTDAA sequencer.
package i3c_daa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_ID    = 3'd2,
        ST_DA    = 3'd3,
        ST_ACK   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // id64_cnt landmarks: bit 6 set marks the 64-bit ID phase, clear marks DA/ACK.
    localparam logic [6:0] CNT_ID_FIRST  = 7'h7F;
    localparam logic [6:0] CNT_ID_LAST   = 7'h40;
    localparam logic [6:0] CNT_DA_FIRST  = 7'h0F;
    localparam logic [6:0] CNT_DA_PARITY = 7'h08;
    localparam logic [6:0] CNT_ACK       = 7'h07;

    function automatic logic is_active(input state_e s);
        return (s == ST_ID) || (s == ST_DA) || (s == ST_ACK);
    endfunction

endpackage

// File: rtl/i3c_daa_seq.sv
// ENTDAA participation sequencer: arbitrates the 64-bit ID on SCL, receives the dynamic
// address and parity, then reports win, loss or retry with a saturating attempt counter.
module i3c_daa_seq
    import i3c_daa_seq_pkg::*;
#(
    parameter logic [3:0] RETRY_MAX = 4'd15
) (
    input  logic       clk_SCL,
    input  logic       RST,
    input  logic       ccc_entdaa,
    input  logic       hdr_7e_ack,
    input  logic       restart_det,
    input  logic       stop_det,
    input  logic       pin_SDA_in,
    input  logic       drv_bit,
    input  logic       has_da,
    input  logic       parity_ok,
    output logic       daa_active,
    output logic [6:0] id64_cnt,
    output logic       daa_lost,
    output logic       daa_won,
    output logic       daa_retry,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [3:0] retry_q, retry_d;
    logic       active_q, active_d;
    logic       lost_q, lost_d;
    logic       won_q, won_d;
    logic       rtry_q, rtry_d;
    // Set by reset or P while ENTDAA is still flagged; only a fresh ENTDAA may re-arm.
    logic       blk_q, blk_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= RETRY_MAX) ? RETRY_MAX : v + 4'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        won_d   = 1'b0;
        rtry_d  = 1'b0;
        blk_d   = (blk_q | stop_det) & ccc_entdaa;

        if (stop_det || !ccc_entdaa) begin
            state_d = ST_IDLE;
            cnt_d   = 7'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!has_da && !blk_q) begin
                        state_d = ST_ARMED;
                        retry_d = 4'd0;
                    end
                end
                ST_ARMED: begin
                    if (hdr_7e_ack) begin
                        state_d = ST_ID;
                        cnt_d   = CNT_ID_FIRST;
                    end
                end
                ST_ID: begin
                    if (restart_det) begin
                        state_d = ST_ARMED;
                        cnt_d   = 7'h00;
                    end else if (!pin_SDA_in && drv_bit) begin
                        state_d = ST_WAIT;
                        cnt_d   = 7'h00;
                        lost_d  = 1'b1;
                        retry_d = sat_inc(retry_q);
                    end else if (cnt_q == CNT_ID_LAST) begin
                        state_d = ST_DA;
                        cnt_d   = CNT_DA_FIRST;
                    end else begin
                        cnt_d   = cnt_q - 7'd1;
                    end
                end
                ST_DA: begin
                    if (restart_det) begin
                        state_d = ST_ARMED;
                        cnt_d   = 7'h00;
                    end else if (cnt_q == CNT_DA_PARITY) begin
                        state_d = ST_ACK;
                        cnt_d   = CNT_ACK;
                    end else begin
                        cnt_d   = cnt_q - 7'd1;
                    end
                end
                ST_ACK: begin
                    cnt_d = 7'h00;
                    if (parity_ok) begin
                        state_d = ST_DONE;
                        won_d   = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                        rtry_d  = 1'b1;
                        retry_d = sat_inc(retry_q);
                    end
                end
                ST_WAIT: begin
                    if (restart_det) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 7'h00;
                end
            endcase
        end

        active_d = is_active(state_d);
    end

    always_ff @(posedge clk_SCL) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 7'h00;
            retry_q  <= 4'd0;
            active_q <= 1'b0;
            lost_q   <= 1'b0;
            won_q    <= 1'b0;
            rtry_q   <= 1'b0;
            blk_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            active_q <= active_d;
            lost_q   <= lost_d;
            won_q    <= won_d;
            rtry_q   <= rtry_d;
            blk_q    <= blk_d;
        end
    end

    assign daa_active = active_q;
    assign id64_cnt   = cnt_q;
    assign daa_lost   = lost_q;
    assign daa_won    = won_q;
    assign daa_retry  = rtry_q;
    assign retry_cnt  = retry_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_i3c_daa_seq.sv
// Directed bench for i3c_daa_seq: expected output snapshots are queued as each step is
// driven and compared after the following SCL rising edge.
module tb_i3c_daa_seq;
    import i3c_daa_seq_pkg::*;

    logic       clk_SCL = 1'b0;
    logic       RST, ccc_entdaa, hdr_7e_ack, restart_det, stop_det;
    logic       pin_SDA_in, drv_bit, has_da, parity_ok;
    logic       daa_active, daa_lost, daa_won, daa_retry;
    logic [6:0] id64_cnt;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic [6:0] cnt;
        logic       lost;
        logic       won;
        logic       rtry;
        logic [3:0] rc;
    } snap_t;

    snap_t sb_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    i3c_daa_seq #(.RETRY_MAX(4'd15)) dut (
        .clk_SCL    (clk_SCL),
        .RST        (RST),
        .ccc_entdaa (ccc_entdaa),
        .hdr_7e_ack (hdr_7e_ack),
        .restart_det(restart_det),
        .stop_det   (stop_det),
        .pin_SDA_in (pin_SDA_in),
        .drv_bit    (drv_bit),
        .has_da     (has_da),
        .parity_ok  (parity_ok),
        .daa_active (daa_active),
        .id64_cnt   (id64_cnt),
        .daa_lost   (daa_lost),
        .daa_won    (daa_won),
        .daa_retry  (daa_retry),
        .retry_cnt  (retry_cnt),
        .seq_state  (seq_state)
    );

    always #5 clk_SCL = ~clk_SCL;

    task automatic expect_out(input string tag, input state_e st, input logic [6:0] cnt,
                              input logic lost, input logic won, input logic rtry,
                              input logic [3:0] rc);
        snap_t e;
        e.st   = st;
        e.act  = (st == ST_ID) || (st == ST_DA) || (st == ST_ACK);
        e.cnt  = cnt;
        e.lost = lost;
        e.won  = won;
        e.rtry = rtry;
        e.rc   = rc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        snap_t obs, e;
        string t;
        @(posedge clk_SCL);
        @(negedge clk_SCL);
        obs = {seq_state, daa_active, id64_cnt, daa_lost, daa_won, daa_retry, retry_cnt};
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // Header, 64 ID bits with SDA following drv_bit, then DA 7'h2A plus odd parity.
    task automatic run_id_da(input logic [3:0] rc);
        logic [7:0] da_bits;
        da_bits     = {7'h2A, ~^7'h2A};
        hdr_7e_ack  = 1'b1;
        expect_out("hdr_to_id", ST_ID, 7'h7F, 1'b0, 1'b0, 1'b0, rc);
        tick();
        hdr_7e_ack  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drv_bit    = 1'($urandom_range(0, 1));
            pin_SDA_in = drv_bit;
            if (i < 63) expect_out("id_bit", ST_ID, 7'(126 - i), 1'b0, 1'b0, 1'b0, rc);
            else        expect_out("id_to_da", ST_DA, 7'h0F, 1'b0, 1'b0, 1'b0, rc);
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            pin_SDA_in = da_bits[7-j];
            if (j < 7) expect_out("da_bit", ST_DA, 7'(14 - j), 1'b0, 1'b0, 1'b0, rc);
            else       expect_out("da_to_ack", ST_ACK, 7'h07, 1'b0, 1'b0, 1'b0, rc);
            tick();
        end
    endtask

    task automatic id_steps(input int n, input logic [3:0] rc);
        for (int i = 0; i < n; i++) begin
            drv_bit    = 1'b1;
            pin_SDA_in = 1'b1;
            expect_out("id_walk", ST_ID, 7'(126 - i), 1'b0, 1'b0, 1'b0, rc);
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; ccc_entdaa = 1'b0; hdr_7e_ack = 1'b0; restart_det = 1'b0;
        stop_det = 1'b0; pin_SDA_in = 1'b1; drv_bit = 1'b0; has_da = 1'b0; parity_ok = 1'b0;

        expect_out("reset", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        RST = 1'b0;
        expect_out("idle_after_reset", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // Already addressed: ENTDAA and headers are ignored.
        ccc_entdaa = 1'b1; has_da = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hdr_7e_ack = (k == 1);
            expect_out("has_da_idle", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
            tick();
        end
        hdr_7e_ack = 1'b0; has_da = 1'b0;
        expect_out("arm", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // Full win.
        run_id_da(4'd0);
        parity_ok = 1'b1;
        expect_out("ack_won", ST_DONE, 7'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        parity_ok = 1'b0; hdr_7e_ack = 1'b1;
        expect_out("done_ignores_hdr", ST_DONE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b0; ccc_entdaa = 1'b0;
        expect_out("done_exit", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // Loss at ID index 20, Sr recovery, then Sr abort inside ID.
        ccc_entdaa = 1'b1;
        expect_out("arm2", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b1;
        expect_out("hdr2", ST_ID, 7'h7F, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b0;
        id_steps(43, 4'd0);
        drv_bit = 1'b1; pin_SDA_in = 1'b0;
        expect_out("lost_pulse", ST_WAIT, 7'h00, 1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        pin_SDA_in = 1'b1;
        expect_out("wait_hold", ST_WAIT, 7'h00, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        restart_det = 1'b1;
        expect_out("sr_rearm", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        restart_det = 1'b0; hdr_7e_ack = 1'b1;
        expect_out("id_restart", ST_ID, 7'h7F, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        hdr_7e_ack = 1'b0; restart_det = 1'b1; drv_bit = 1'b1; pin_SDA_in = 1'b0;
        expect_out("sr_abort_no_lost", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        restart_det = 1'b0; pin_SDA_in = 1'b1;

        // Sixteen bad-parity retries saturate the counter.
        for (int r = 0; r < 16; r++) begin
            run_id_da(4'((r + 1 > 15) ? 15 : r + 1));
            parity_ok = 1'b0;
            expect_out("ack_retry", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b1,
                       4'((r + 2 > 15) ? 15 : r + 2));
            tick();
        end

        // P coincident with header wins over ARMED->ID.
        hdr_7e_ack = 1'b1; stop_det = 1'b1;
        expect_out("stop_vs_hdr", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd15);
        tick();
        hdr_7e_ack = 1'b0; stop_det = 1'b0;
        expect_out("stop_stays_idle", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd15);
        tick();
        ccc_entdaa = 1'b0;
        expect_out("entdaa_low", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd15);
        tick();

        // Reset at ID index 30; a header alone must not resume.
        ccc_entdaa = 1'b1;
        expect_out("arm3_clears_rc", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b1;
        expect_out("hdr3", ST_ID, 7'h7F, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b0;
        id_steps(33, 4'd0);
        RST = 1'b1;
        expect_out("rst_mid_id", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        RST = 1'b0; hdr_7e_ack = 1'b1;
        expect_out("hdr_after_rst_ignored", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b0;
        expect_out("still_idle", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        ccc_entdaa = 1'b0;
        expect_out("entdaa_drop", ST_IDLE, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        ccc_entdaa = 1'b1;
        expect_out("new_entdaa", ST_ARMED, 7'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b1;
        expect_out("resume_id", ST_ID, 7'h7F, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        hdr_7e_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
